// File: rtl/nano_wait_mem.sv
// Word-addressed memory with a ce/we request handshake and independent read/write wait states.
// A one-cycle ready pulse completes each request; err flags addresses beyond DEPTH.
module nano_wait_mem #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned WR_LAT = 0
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              ce,
   input  logic              we,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] dataW,
   output logic [DATA_W-1:0] dataR,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   if (DATA_W < 1 || ADDR_W < 1 || DEPTH < 1 || 64'(DEPTH) > (64'd1 << ADDR_W) ||
       RD_LAT > 15 || WR_LAT > 15) begin : g_param_check
      $error("nano_wait_mem: parameter out of range");
   end

   localparam bit          HAS_ERR = 64'(DEPTH) < (64'd1 << ADDR_W);
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wd_q, wd_d;
   logic [DATA_W-1:0]   dataR_q;
   logic                access;
   logic                oor;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   mem [DEPTH];

   if (HAS_ERR) begin : g_err
      localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
      assign oor = (addr_q >= DEPTH_A);
   end else begin : g_no_err
      assign oor = 1'b0;
   end

   assign idx = IDX_W'(addr_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wd_d    = wd_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ce) begin
               addr_d  = address;
               we_d    = we;
               wd_d    = dataW;
               cnt_d   = we ? 4'(WR_LAT) : 4'(RD_LAT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wd_q    <= '0;
         dataR_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wd_q    <= wd_d;
         if (access && !we_q) begin
            dataR_q <= oor ? '0 : mem[idx];
         end
      end
   end

   // Array is deliberately left out of reset; a write only commits on the access edge.
   always_ff @(posedge ck) begin
      if (access && we_q && !oor) begin
         mem[idx] <= wd_q;
      end
   end

   assign dataR = dataR_q;
   assign ready = (state_q == RESP);
   assign busy  = (state_q != IDLE);
   assign err   = ready && oor;

endmodule

// File: tb/tb_nano_wait_mem.sv
// Directed bench for nano_wait_mem: five instances cover DEPTH=200/256, RD_LAT 0/1/2/7/15 and WR_LAT 0/5.
module tb_nano_wait_mem;

   localparam int N = 5;

   logic              ck;
   logic [N-1:0]      rst_n;
   logic [N-1:0]      ce;
   logic              we;
   logic [7:0]        address;
   logic [15:0]       dataW;
   logic [15:0]       dataR [N];
   logic [N-1:0]      ready;
   logic [N-1:0]      busy;
   logic [N-1:0]      err;

   int checks   = 0;
   int failures = 0;

   // Instance k: RD_LAT = {2,0,1,7,15}[k], WR_LAT = 5 only for k=4, DEPTH = 200 only for k=0.
   for (genvar g = 0; g < N; g++) begin : g_dut
      nano_wait_mem #(
         .DATA_W(16),
         .ADDR_W(8),
         .DEPTH (g == 0 ? 200 : 256),
         .RD_LAT(g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 1 : g == 3 ? 7 : 15),
         .WR_LAT(g == 4 ? 5 : 0)
      ) u_dut (
         .ck     (ck),
         .rst    (rst_n[g]),
         .ce     (ce[g]),
         .we     (we),
         .address(address),
         .dataW  (dataW),
         .dataR  (dataR[g]),
         .ready  (ready[g]),
         .busy   (busy[g]),
         .err    (err[g])
      );
   end

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   // Issue one request on instance k; returns edges from acceptance to ready, plus dataR/err at ready.
   task automatic run_req(input int k, input logic w, input logic [7:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic e);
      ce[k]   = 1'b1;
      we      = w;
      address = a;
      dataW   = d;
      tick();
      ce[k] = 1'b0;
      check_eq($sformatf("busy_after_accept_%0d", k), 32'(busy[k]), 32'd1);
      lat = 0;
      while (!ready[k] && lat < 40) begin
         tick();
         lat++;
      end
      rd = dataR[k];
      e  = err[k];
      tick();
      check_eq($sformatf("ready_width_%0d", k), 32'(ready[k]), 32'd0);
      check_eq($sformatf("err_clear_%0d", k), 32'(err[k]), 32'd0);
      check_eq($sformatf("busy_done_%0d", k), 32'(busy[k]), 32'd0);
   endtask

   initial begin
      int          lat;
      logic [15:0] rd;
      logic        e;
      int          rl [N] = '{2, 0, 1, 7, 15};
      int          wl [N] = '{0, 0, 0, 0, 5};
      int          pulses [$];
      logic        seen_ready;

      rst_n = '0; ce = '0; we = 1'b0; address = '0; dataW = '0;

      // Reset and idle
      tick(); tick();
      check_eq("rst_ready", 32'(ready), 32'd0);
      check_eq("rst_busy",  32'(busy),  32'd0);
      check_eq("rst_err",   32'(err),   32'd0);
      check_eq("rst_dataR0", 32'(dataR[0]), 32'd0);
      check_eq("rst_dataR4", 32'(dataR[4]), 32'd0);
      rst_n = '1;
      tick(); tick();
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_ready", 32'(ready), 32'd0);

      // Write then read, RD_LAT=2, WR_LAT=0
      run_req(0, 1'b1, 8'h0A, 16'h1234, lat, rd, e);
      check_eq("wr_lat", 32'(lat), 32'd1);
      check_eq("wr_err", 32'(e), 32'd0);
      check_eq("wr_dataR_unchanged", 32'(rd), 32'h0);
      run_req(0, 1'b0, 8'h0A, 16'h0000, lat, rd, e);
      check_eq("rd_lat", 32'(lat), 32'd3);
      check_eq("rd_data", 32'(rd), 32'h1234);
      check_eq("rd_err", 32'(e), 32'd0);

      // Wait-state sweep on 8'h05
      for (int k = 1; k < N; k++) begin
         run_req(k, 1'b1, 8'h05, 16'h0500 + 16'(k), lat, rd, e);
         check_eq($sformatf("sweep_wr_lat_%0d", k), 32'(lat), 32'(wl[k] + 1));
         run_req(k, 1'b0, 8'h05, 16'h0000, lat, rd, e);
         check_eq($sformatf("sweep_rd_lat_%0d", k), 32'(lat), 32'(rl[k] + 1));
         check_eq($sformatf("sweep_rd_data_%0d", k), 32'(rd), 32'h0500 + 32'(k));
      end

      // ce held high: reads accepted only in IDLE, one per RD_LAT+3 = 5 cycles
      ce[0] = 1'b1; we = 1'b0; address = 8'h0A;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ready[0]) pulses.push_back(i);
      end
      ce[0] = 1'b0;
      check_eq("held_count", 32'(pulses.size()), 32'd4);
      if (pulses.size() >= 2) begin
         check_eq("held_first", 32'(pulses[0]), 32'd4);
         check_eq("held_gap", 32'(pulses[1] - pulses[0]), 32'd5);
      end else begin
         check_eq("held_pulses_missing", 32'(pulses.size()), 32'd4);
      end
      tick();
      check_eq("held_idle", 32'(busy[0]), 32'd0);

      // Inputs changed during WAIT are ignored
      ce[0] = 1'b1; we = 1'b0; address = 8'h0A;
      tick();
      ce[0] = 1'b0; we = 1'b1; address = 8'h20; dataW = 16'hFFFF;
      tick(); tick(); tick();
      check_eq("chg_ready", 32'(ready[0]), 32'd1);
      check_eq("chg_data", 32'(dataR[0]), 32'h1234);
      tick();

      // Out of range on DEPTH=200
      run_req(0, 1'b1, 8'hC8, 16'hBEEF, lat, rd, e);
      check_eq("oor_wr_lat", 32'(lat), 32'd1);
      check_eq("oor_wr_err", 32'(e), 32'd1);
      check_eq("oor_wr_dataR_kept", 32'(rd), 32'h1234);
      run_req(0, 1'b0, 8'hC8, 16'h0000, lat, rd, e);
      check_eq("oor_rd_data", 32'(rd), 32'h0);
      check_eq("oor_rd_err", 32'(e), 32'd1);
      run_req(0, 1'b1, 8'hC7, 16'h7777, lat, rd, e);
      run_req(0, 1'b0, 8'hC7, 16'h0000, lat, rd, e);
      check_eq("edge_rd_err", 32'(e), 32'd0);
      check_eq("edge_rd_data", 32'(rd), 32'h7777);
      run_req(1, 1'b0, 8'hFF, 16'h0000, lat, rd, e);
      check_eq("full_depth_err", 32'(e), 32'd0);

      // Reset two cycles into a WR_LAT=5 write
      run_req(4, 1'b1, 8'h03, 16'h5555, lat, rd, e);
      check_eq("prior_wr_lat", 32'(lat), 32'd6);
      ce[4] = 1'b1; we = 1'b1; address = 8'h03; dataW = 16'hAAAA;
      tick();
      ce[4] = 1'b0;
      tick(); tick();
      rst_n[4] = 1'b0;
      #1;
      check_eq("midrst_busy", 32'(busy[4]), 32'd0);
      check_eq("midrst_ready", 32'(ready[4]), 32'd0);
      check_eq("midrst_dataR", 32'(dataR[4]), 32'd0);
      tick();
      rst_n[4] = 1'b1;
      seen_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen_ready |= ready[4];
      end
      check_eq("midrst_no_ready", 32'(seen_ready), 32'd0);
      run_req(4, 1'b0, 8'h03, 16'h0000, lat, rd, e);
      check_eq("midrst_rd_lat", 32'(lat), 32'd16);
      check_eq("midrst_rd_data", 32'(rd), 32'h5555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nano_wait_mem.md
Name: nano_wait_mem

Overview:
Parametrised word-addressed memory for the NanoCPU family. It generalises the zero-latency bench memory to configurable data/address width, depth, and independent read/write wait states. A ce/we request handshake with a one-cycle ready pulse lets CPU variants run against slow memory. Out-of-range accesses are reported on err. It sits on the CPU address/dataR/dataW/ce/we bus and replaces the combinational bench memory.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of implemented words, 1..2**ADDR_W
RD_LAT, 2, read wait states, 0..15
WR_LAT, 0, write wait states, 0..15

Ports:
ck  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
ce  in  1  request strobe; sampled only in IDLE
we  in  1  1=write, 0=read; sampled with ce
address  in  ADDR_W  word address; sampled with ce
dataW  in  DATA_W  write data; sampled with ce
dataR  out  DATA_W  read data; registered, valid when ready=1, held until next read completes
ready  out  1  one-cycle completion pulse
busy  out  1  1 while a request is outstanding (state != IDLE)
err  out  1  pulses with ready when the latched address >= DEPTH

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, dataR=0, ready=0, busy=0, err=0. Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with ce=1, latch addr_q, we_q and wd_q.
  - Load cnt = we ? WR_LAT : RD_LAT, then go to WAIT.
  - ce=0: stay in IDLE.
- WAIT:
  - Each edge with cnt!=0: cnt-1.
  - Edge with cnt==0: go to RESP and perform the access on that edge.
- Access rules:
  - Write, addr_q<DEPTH: mem[addr_q]<=wd_q.
  - Read, addr_q<DEPTH: dataR<=mem[addr_q].
  - addr_q>=DEPTH: write discarded, dataR<=0, err<=1.
- RESP: ready=1 (and err if flagged) for exactly this one cycle. Next edge: ready=0, err=0, go to IDLE.
- Latency: ready is high in the cycle after edge (LAT+1), where edge 0 is the accepting edge. RD_LAT=0 therefore gives ready one cycle after acceptance.
- Throughput: at most one request per LAT+3 cycles. ce in WAIT or RESP is ignored; the requester must re-present it in IDLE.
- Inputs are sampled only at acceptance. Changes to address, dataW or we during WAIT have no effect.
- Read-after-write to the same address returns the new value, because the write commits before the next acceptance.
- dataR changes only on read completion (or reset); a write completion leaves dataR unchanged.
- Out-of-range detection: err logic exists only when DEPTH < 2**ADDR_W; otherwise err is constant 0.
- Reset mid-operation: request aborted, a pending write is not committed, no ready pulse, outputs at reset values.
- cnt width: 4 bits. Parameters outside their stated ranges are a compile-time error.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, ce=0 -> dataR=0, ready=0, busy=0, err=0 throughout.
- Write then read, RD_LAT=2, WR_LAT=0:
  - Write: ce=1, we=1, address=8'h0A, dataW=16'h1234 -> ready one cycle after acceptance, busy=1 meanwhile.
  - Read: ce=1, we=0, address=8'h0A -> ready exactly 3 cycles after acceptance, with dataR=16'h1234.
- Wait-state sweep: RD_LAT in {0,1,7,15}, read from 8'h05 -> ready pulse width is exactly 1 cycle, arriving RD_LAT+1 cycles after acceptance.
- Ignored and changed inputs:
  - ce held 1 continuously -> requests accepted only in IDLE, spaced LAT+3 cycles apart.
  - address changed during WAIT -> original address used.
- Out of range, DEPTH=200: write 16'hBEEF to 8'hC8 -> ready=1 and err=1 together. Read 8'hC8 -> dataR=0, err=1. Read 8'hC7 -> err=0.
- Reset mid-write, WR_LAT=5: rst=0 two cycles after accepting a write of 16'hAAAA to 8'h03 -> no ready, busy=0, and a later read of 8'h03 returns the prior contents.
